// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, default frame
// geometry and the 2-of-3 majority vote used on every sampled bit.
package uart_pkg;

   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned DEF_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sample_tick_gen.sv
// Oversampling tick generator: one-cycle tick every (div_q + 1) sys_clk cycles,
// divisor captured at frame start so mid-frame div_value changes are ignored.
module uart_sample_tick_gen #(
   parameter int unsigned pDIV_WIDTH = 16
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic                  load,
   input  logic [pDIV_WIDTH-1:0] div_value,
   output logic                  tick
);

   localparam logic [pDIV_WIDTH-1:0] DIV_ONE = pDIV_WIDTH'(1);

   logic [pDIV_WIDTH-1:0] div_cnt_r;
   logic [pDIV_WIDTH-1:0] div_q_r;
   logic                  at_top_s;

   assign at_top_s = (div_cnt_r == div_q_r);
   assign tick     = at_top_s & ~hold;

   // Divisor capture at start detection.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         div_q_r <= '0;
      end else if (load) begin
         div_q_r <= div_value;
      end
   end

   // Divider counter: parked at zero while held, wraps on every tick.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         div_cnt_r <= '0;
      end else if (hold || at_top_s) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_ONE;
      end
   end

endmodule

// File: rtl/uart_rx_sample_ctrl.sv
// UART receive sampling controller: synchronizes rx, sequences start/data/stop
// sampling with a mid-bit 3-sample majority vote and reports each frame.
module uart_rx_sample_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned pDATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned pOVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned pDIV_WIDTH  = 16
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [pDIV_WIDTH-1:0] div_value,
   input  logic                  enable,
   input  logic                  rx,
   output logic [pDATA_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned SIDX_W = $clog2(pOVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(pDATA_BITS);
   localparam int unsigned M      = pOVERSAMPLE / 2;

   localparam logic [SIDX_W-1:0] S_PRE    = SIDX_W'(M - 1);
   localparam logic [SIDX_W-1:0] S_MID    = SIDX_W'(M);
   localparam logic [SIDX_W-1:0] S_VOTE   = SIDX_W'(M + 1);
   localparam logic [SIDX_W-1:0] S_LAST   = SIDX_W'(pOVERSAMPLE - 1);
   localparam logic [SIDX_W-1:0] SIDX_ONE = SIDX_W'(1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(pDATA_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

   rx_state_t             state_r;
   rx_state_t             next_state_s;
   logic [1:0]            sync_r;
   logic                  rx_s;
   logic                  tick_s;
   logic [SIDX_W-1:0]     s_idx_r;
   logic [BIT_W-1:0]      bit_cnt_r;
   logic [1:0]            samp_r;
   logic [pDATA_BITS-1:0] shift_r;
   logic                  vote_s;
   logic                  start_det_s;
   logic                  at_pre_s;
   logic                  at_mid_s;
   logic                  at_vote_s;
   logic                  at_end_s;
   logic                  tick_hold_s;
   logic                  shift_en_s;
   logic                  bit_adv_s;
   logic                  frame_done_s;
   logic [pDATA_BITS-1:0] rx_data_r;
   logic                  rx_valid_r;
   logic                  frame_err_r;
   logic                  busy_r;

   assign rx_s        = sync_r[1];
   assign start_det_s = (state_r == IDLE) & enable & ~rx_s;
   assign at_pre_s    = tick_s & (s_idx_r == S_PRE);
   assign at_mid_s    = tick_s & (s_idx_r == S_MID);
   assign at_vote_s   = tick_s & (s_idx_r == S_VOTE);
   assign at_end_s    = tick_s & (s_idx_r == S_LAST);
   // Third sample is taken live on the voting tick.
   assign vote_s      = majority3(samp_r[0], samp_r[1], rx_s);

   uart_sample_tick_gen #(
      .pDIV_WIDTH(pDIV_WIDTH)
   ) u_tick_gen (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .hold     (tick_hold_s),
      .load     (start_det_s),
      .div_value(div_value),
      .tick     (tick_s)
   );

   // Two-flop synchronizer for the asynchronous line.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], rx};
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; STOP leaves at the vote tick so the next edge is caught.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_det_s) next_state_s = START;
            else             next_state_s = IDLE;
         end
         START: begin
            if (at_vote_s && vote_s) next_state_s = IDLE;
            else if (at_end_s)       next_state_s = DATA;
            else                     next_state_s = START;
         end
         DATA: begin
            if (at_end_s && (bit_cnt_r == LAST_BIT)) next_state_s = STOP;
            else                                     next_state_s = DATA;
         end
         STOP: begin
            if (at_vote_s) next_state_s = IDLE;
            else           next_state_s = STOP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Per-state datapath strobes.
   always_comb begin
      tick_hold_s  = 1'b0;
      shift_en_s   = 1'b0;
      bit_adv_s    = 1'b0;
      frame_done_s = 1'b0;
      case (state_r)
         IDLE:  tick_hold_s = 1'b1;
         START: tick_hold_s = 1'b0;
         DATA: begin
            shift_en_s = at_vote_s;
            bit_adv_s  = at_end_s & (bit_cnt_r != LAST_BIT);
         end
         STOP:    frame_done_s = at_vote_s;
         default: tick_hold_s  = 1'b1;
      endcase
   end

   // Sample index and bit counter, both parked at zero outside a frame.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         s_idx_r   <= '0;
         bit_cnt_r <= '0;
      end else if (state_r == IDLE) begin
         s_idx_r   <= '0;
         bit_cnt_r <= '0;
      end else begin
         if (at_end_s)    s_idx_r <= '0;
         else if (tick_s) s_idx_r <= s_idx_r + SIDX_ONE;
         if (bit_adv_s)   bit_cnt_r <= bit_cnt_r + BIT_ONE;
      end
   end

   // Early mid-bit samples and LSB-first shift register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         samp_r  <= 2'b11;
         shift_r <= '0;
      end else begin
         if (at_pre_s)    samp_r[0] <= rx_s;
         if (at_mid_s)    samp_r[1] <= rx_s;
         if (start_det_s) shift_r   <= '0;
         else if (shift_en_s) shift_r <= {vote_s, shift_r[pDATA_BITS-1:1]};
      end
   end

   // Registered frame results and busy flag.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         rx_data_r   <= '0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         if (frame_done_s) rx_data_r <= shift_r;
         rx_valid_r  <= frame_done_s & vote_s;
         frame_err_r <= frame_done_s & ~vote_s;
         busy_r      <= (next_state_s != IDLE);
      end
   end

   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// Directed self-checking bench for uart_rx_sample_ctrl: frames are driven
// bit by bit and outputs are compared with hand-computed values.
module tb_uart_rx_sample_ctrl;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] div_value = 16'd0;
   logic        enable = 1'b0;
   logic        rx = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_sample_ctrl #(
      .pDATA_BITS (8),
      .pOVERSAMPLE(16),
      .pDIV_WIDTH (16)
   ) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .div_value(div_value),
      .enable   (enable),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Output monitor sampled on the falling edge.
   int         cyc = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         busy_cyc = 0;
   int         busy_bad = 0;
   int         pulse_bad = 0;
   int         last_valid_cyc = 0;
   int         prev_valid_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;
   logic       busy_q = 1'b0;
   logic       valid_q = 1'b0;
   logic       err_q = 1'b0;

   always @(negedge sys_clk) begin
      cyc     <= cyc + 1;
      busy_q  <= busy;
      valid_q <= rx_valid;
      err_q   <= frame_err;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (rx_valid) begin
         valid_cnt      <= valid_cnt + 1;
         prev_data      <= last_data;
         last_data      <= rx_data;
         prev_valid_cyc <= last_valid_cyc;
         last_valid_cyc <= cyc;
         if (busy || !busy_q) busy_bad <= busy_bad + 1;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if ((rx_valid && frame_err) || (rx_valid && valid_q) || (frame_err && err_q))
         pulse_bad <= pulse_bad + 1;
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int cpb, input int goff);
      for (int c = 0; c < cpb; c++) begin
         rx = (c == goff) ? ~b : b;
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb,
                             input int gbit, input int goff);
      send_bit(1'b0, cpb, -1);
      for (int i = 0; i < 8; i++) send_bit(d[i], cpb, (i == gbit) ? goff : -1);
      send_bit(stop, cpb, -1);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
      idle(10);
   endtask

   task automatic test_basic();
      int v0, e0, b0;
      div_value = 16'd0;
      enable    = 1'b1;
      idle(20);
      v0 = valid_cnt; e0 = err_cnt; b0 = busy_bad;
      send_frame(8'hA5, 1'b1, 16, -1, -1);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_pulses: got %0d expected 1", valid_cnt - v0); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d expected 0", err_cnt - e0); end
      n_checks++; if (last_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", last_data); end
      n_checks++; if (busy_bad - b0 !== 0) begin n_fail++; $display("FAIL basic_busy_fall: got %0d misaligned expected 0", busy_bad - b0); end
   endtask

   task automatic test_false_start();
      int v0, e0, c0;
      v0 = valid_cnt; e0 = err_cnt; c0 = busy_cyc;
      rx = 1'b0;
      repeat (4) @(posedge sys_clk);
      #1;
      idle(30);
      n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL false_start_valid: got %0d expected 0", valid_cnt - v0); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL false_start_err: got %0d expected 0", err_cnt - e0); end
      n_checks++; if (busy_cyc - c0 !== 10) begin n_fail++; $display("FAIL false_start_busy_cycles: got %0d expected 10", busy_cyc - c0); end
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b1, 16, -1, -1);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL after_false_valid: got %0d expected 1", valid_cnt - v0); end
      n_checks++; if (last_data !== 8'h3C) begin n_fail++; $display("FAIL after_false_data: got %h expected 3c", last_data); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL after_false_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_frame_err();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, 16, -1, -1);
      idle(40);
      n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", err_cnt - e0); end
      n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - v0); end
      n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %h expected 3c", rx_data); end
   endtask

   task automatic test_glitch();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h81, 1'b1, 16, 3, 8);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 1", valid_cnt - v0); end
      n_checks++; if (last_data !== 8'h81) begin n_fail++; $display("FAIL glitch_data: got %h expected 81", last_data); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      int v0, e0;
      logic [7:0] d;
      div_value = 16'd9;
      idle(20);
      v0 = valid_cnt; e0 = err_cnt;
      for (int f = 0; f < 2; f++) begin
         d = (f == 0) ? 8'h00 : 8'hFF;
         send_bit(1'b0, 160, -1);
         for (int i = 0; i < 8; i++) begin
            if (i == 4) div_value = 16'd3;
            send_bit(d[i], 160, -1);
         end
         div_value = 16'd9;
         send_bit(1'b1, 160, -1);
      end
      idle(20);
      n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_pulses: got %0d expected 2", valid_cnt - v0); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
      n_checks++; if (prev_data !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 00", prev_data); end
      n_checks++; if (last_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data: got %h expected ff", last_data); end
      n_checks++; if (last_valid_cyc - prev_valid_cyc !== 1600) begin n_fail++; $display("FAIL b2b_pulse_spacing: got %0d expected 1600", last_valid_cyc - prev_valid_cyc); end
   endtask

   task automatic test_reset_midframe();
      int v0, e0;
      logic [7:0] d;
      d = 8'h96;
      div_value = 16'd0;
      idle(20);
      send_bit(1'b0, 16, -1);
      for (int i = 0; i < 4; i++) send_bit(d[i], 16, -1);
      rx = d[4];
      repeat (8) @(posedge sys_clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", busy); end
      rst = 1'b1;
      @(negedge sys_clk);
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if ((rx_valid | frame_err) !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got %b%b expected 00", rx_valid, frame_err); end
      @(posedge sys_clk);
      #1;
      rx = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      rst = 1'b0;
      idle(30);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h5A, 1'b1, 16, -1, -1);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL postrst_valid: got %0d expected 1", valid_cnt - v0); end
      n_checks++; if (last_data !== 8'h5A) begin n_fail++; $display("FAIL postrst_data: got %h expected 5a", last_data); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL postrst_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_enable_off();
      int v0, e0, c0;
      enable = 1'b0;
      idle(5);
      v0 = valid_cnt; e0 = err_cnt; c0 = busy_cyc;
      send_frame(8'hC3, 1'b1, 16, -1, -1);
      idle(20);
      n_checks++; if (busy_cyc - c0 !== 0) begin n_fail++; $display("FAIL disabled_busy_cycles: got %0d expected 0", busy_cyc - c0); end
      n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL disabled_valid: got %0d expected 0", valid_cnt - v0); end
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL disabled_err: got %0d expected 0", err_cnt - e0); end
      n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL disabled_rx_data: got %h expected 5a", rx_data); end
   endtask

   task automatic test_pulse_shape();
      n_checks++; if (pulse_bad !== 0) begin n_fail++; $display("FAIL pulse_shape: got %0d bad pulses expected 0", pulse_bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      test_enable_off();
      test_pulse_shape();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
